// File: rtl/proc_pkg.sv
// Shared pipeline constants: datapath widths, special register indices and the
// opcode encodings used by the writeback-side decoder and the register file.
package proc_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  typedef enum logic [4:0] {
    OP_RTYPE = 5'b00000,
    OP_ADDI  = 5'b00101,
    OP_LW    = 5'b01000,
    OP_JAL   = 5'b00011
  } opcode_t;

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback request and decode read-port bundle for the register file.
// master = pipeline side, slave = register file.
interface wb_regfile_if;
  import proc_pkg::*;

  logic              wb_we;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rs_a;
  logic [ADDR_W-1:0] rs_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  modport master (
    output wb_we, wb_reg, wb_data, rd_en, rs_a, rs_b,
    input  rd_a, rd_b
  );

  modport slave (
    input  wb_we, wb_reg, wb_data, rd_en, rs_a, rs_b,
    output rd_a, rd_b
  );

endinterface

// File: rtl/wb_regfile_read_port.sv
// One registered read port: zero-index check, same-cycle write bypass,
// array mux and an output register that holds while rd_en is low.
module rf_read_port
  import proc_pkg::*;
(
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              i_rd_en,
  input  logic [ADDR_W-1:0]                 i_rs,
  input  logic                              i_wb_we,
  input  logic [ADDR_W-1:0]                 i_wb_reg,
  input  logic [DATA_W-1:0]                 i_wb_data,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]   i_regs,
  output logic [DATA_W-1:0]                 o_rd
);

  logic [DATA_W-1:0] w_next;
  logic [DATA_W-1:0] r_rd;

  always_comb begin
    w_next = i_regs[i_rs];
    if (i_rs == REG_ZERO) begin
      w_next = '0;
    end else if (i_wb_we && (i_wb_reg == i_rs)) begin
      w_next = i_wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rd <= '0;
    end else if (i_rd_en) begin
      r_rd <= w_next;
    end
  end

  assign o_rd = r_rd;

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file terminating the writeback stage: 31 stored
// registers plus hardwired zero, two registered read ports with write bypass.
module wb_regfile
  import proc_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  wb_regfile_if.slave  bus
);

  logic [NUM_REGS-1:1][DATA_W-1:0] r_regs;
  logic [NUM_REGS-1:0][DATA_W-1:0] w_regs;

  // Index 0 carries no storage; the read ports see a constant zero there.
  assign w_regs = {r_regs, {DATA_W{1'b0}}};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_regs <= '0;
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (bus.wb_we && (bus.wb_reg == ADDR_W'(i))) begin
          r_regs[i] <= bus.wb_data;
        end
      end
    end
  end

  rf_read_port u_port_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_rd_en   (bus.rd_en),
    .i_rs      (bus.rs_a),
    .i_wb_we   (bus.wb_we),
    .i_wb_reg  (bus.wb_reg),
    .i_wb_data (bus.wb_data),
    .i_regs    (w_regs),
    .o_rd      (bus.rd_a)
  );

  rf_read_port u_port_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_rd_en   (bus.rd_en),
    .i_rs      (bus.rs_b),
    .i_wb_we   (bus.wb_we),
    .i_wb_reg  (bus.wb_reg),
    .i_wb_data (bus.wb_data),
    .i_regs    (w_regs),
    .o_rd      (bus.rd_b)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a reference register-file model checked every
// cycle, plus literal expectations at the key steps of each scenario.
module tb_wb_regfile;
  import proc_pkg::*;

  logic clock = 1'b0;
  logic reset_n;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: an array of 32 words plus the two output values.
  logic [31:0] m_mem [32];
  logic [31:0] m_rd_a = '0;
  logic [31:0] m_rd_b = '0;

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.wb_we && bus.wb_reg == idx) return bus.wb_data;
    return m_mem[idx];
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < 32; k++) m_mem[k] = '0;
      m_rd_a = '0;
      m_rd_b = '0;
    end else begin
      if (bus.rd_en) begin
        m_rd_a = model_read(bus.rs_a);
        m_rd_b = model_read(bus.rs_b);
      end
      if (bus.wb_we && bus.wb_reg != 5'd0) m_mem[bus.wb_reg] = bus.wb_data;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_rd_a", bus.rd_a, m_rd_a);
      check("model_rd_b", bus.rd_b, m_rd_b);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic we, input logic [4:0] r, input logic [31:0] d);
    bus.wb_we   = we;
    bus.wb_reg  = r;
    bus.wb_data = d;
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.rd_en   = 1'b1;
    bus.rs_a    = 5'd5;
    bus.rs_b    = 5'd5;
    wr(1'b1, 5'd5, 32'hDEAD_BEEF);

    // Reset held two cycles with a write presented
    tick();
    chk_en = 1'b1;
    check("rst1_a", bus.rd_a, 32'h0);
    check("rst1_b", bus.rd_b, 32'h0);
    tick();
    check("rst2_a", bus.rd_a, 32'h0);
    check("rst2_b", bus.rd_b, 32'h0);
    reset_n = 1'b1;
    wr(1'b0, 5'd0, 32'h0);
    tick();
    check("post_rst_reg5", bus.rd_a, 32'h0);

    // Basic write then read on both ports
    wr(1'b1, 5'd7, 32'h1234_5678);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    bus.rs_a = 5'd7;
    bus.rs_b = 5'd7;
    tick();
    check("basic_a", bus.rd_a, 32'h1234_5678);
    check("basic_b", bus.rd_b, 32'h1234_5678);

    // Register 0 ignores writes, same cycle and later
    wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    bus.rs_a = 5'd0;
    tick();
    check("r0_same", bus.rd_a, 32'h0);
    check("r0_other_port", bus.rd_b, 32'h1234_5678);
    wr(1'b0, 5'd0, 32'h0);
    tick();
    check("r0_later", bus.rd_a, 32'h0);

    // Bypass: reg31 holds 0x99, jal link write of 0x40 read same edge
    wr(1'b1, 5'd31, 32'h0000_0099);
    tick();
    wr(1'b1, REG_RA, 32'h0000_0040);
    bus.rs_a = 5'd7;
    bus.rs_b = 5'd31;
    tick();
    check("bypass_b", bus.rd_b, 32'h0000_0040);
    check("bypass_a_array", bus.rd_a, 32'h1234_5678);
    wr(1'b0, 5'd0, 32'h0);
    tick();
    check("after_bypass_b", bus.rd_b, 32'h0000_0040);

    // Both ports bypassing in the same cycle
    wr(1'b1, 5'd12, 32'h00C0_FFEE);
    bus.rs_a = 5'd12;
    bus.rs_b = 5'd12;
    tick();
    check("dual_bypass_a", bus.rd_a, 32'h00C0_FFEE);
    check("dual_bypass_b", bus.rd_b, 32'h00C0_FFEE);

    // Stall hold
    wr(1'b1, 5'd3, 32'hA);
    bus.rs_a = 5'd1;
    tick();
    wr(1'b0, 5'd0, 32'h0);
    bus.rs_a = 5'd3;
    tick();
    check("stall_pre", bus.rd_a, 32'hA);
    bus.rd_en = 1'b0;
    bus.rs_a  = 5'd4;
    wr(1'b1, 5'd3, 32'hB);
    tick();
    check("stall_hold1", bus.rd_a, 32'hA);
    wr(1'b0, 5'd0, 32'h0);
    tick();
    check("stall_hold2", bus.rd_a, 32'hA);
    tick();
    check("stall_hold3", bus.rd_a, 32'hA);
    bus.rd_en = 1'b1;
    bus.rs_a  = 5'd3;
    tick();
    check("stall_release", bus.rd_a, 32'hB);

    // Back-to-back writes to one index: last wins
    wr(1'b1, 5'd20, 32'h1);
    bus.rs_a = 5'd20;
    tick();
    check("b2b_first", bus.rd_a, 32'h1);
    wr(1'b1, 5'd20, 32'h2);
    tick();
    check("b2b_second", bus.rd_a, 32'h2);
    wr(1'b0, 5'd0, 32'h0);
    tick();
    check("b2b_array", bus.rd_a, 32'h2);

    // Sweep every index: port A bypasses, port B reads the previous index
    for (int i = 1; i < 32; i++) begin
      wr(1'b1, 5'(i), 32'h0101_0101 * i);
      bus.rs_a = 5'(i);
      bus.rs_b = 5'(i - 1);
      tick();
    end
    wr(1'b0, 5'd0, 32'h0);
    bus.rs_a = 5'd31;
    bus.rs_b = 5'd16;
    tick();
    check("sweep_r31", bus.rd_a, 32'h1F1F_1F1F);
    check("sweep_r16", bus.rd_b, 32'h1010_1010);

    // Reset mid-stream drops a concurrent write
    wr(1'b1, 5'd9, 32'h11);
    tick();
    reset_n = 1'b0;
    wr(1'b1, 5'd9, 32'h55);
    bus.rs_a = 5'd9;
    tick();
    check("midrst_a", bus.rd_a, 32'h0);
    check("midrst_b", bus.rd_b, 32'h0);
    reset_n = 1'b1;
    wr(1'b0, 5'd0, 32'h0);
    bus.rs_b = 5'd7;
    tick();
    check("midrst_reg9", bus.rd_a, 32'h0);
    check("midrst_reg7", bus.rd_b, 32'h0);
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
